sdram_port_arbiter: RTL and testbench

- Shares one memory_controller instance between NUM_REQ requesters.
- Round-robin arbitration; one transaction in flight at a time.
- Latches the winner's command and drives the controller's RE_IN/WE_IN/ADR_IN/BDR_IN/DIN.
- Tracks completion by MC_RDY rising edges, returns read data, ACKs the requester, and flags hung transactions.

---
 rtl/sdram_port_arbiter_pkg.sv | 15 +
 rtl/sdram_port_arbiter_rr_arbiter.sv | 43 ++++
 rtl/sdram_port_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_port_arbiter_pkg.sv
// Shared state encoding and default controller widths for the SDRAM port arbiter.
// Pure declarations; no latency or flow control of its own.
package sdram_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Must track the memory_controller instance this arbiter fronts.
    localparam int SDRAM_BANK_ADRESS  = 2;
    localparam int SDRAM_ROW_ADRESS   = 13;
    localparam int SDRAM_COLUMN_WIDTH = 16;

endpackage

// File: rtl/sdram_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick starting after ptr; zero latency, no backpressure.
// SDRAM_ARB_PRIO0_EN makes requester 0 fixed highest priority without moving the pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PW-1:0]      idx,
    output logic               vld,
    output logic               ptr_upd
);

    logic [PW-1:0] cand;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        vld     = 1'b0;
        ptr_upd = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PW'((int'(ptr) + k) % NUM_REQ);
            if (!vld && req[cand]) begin
                vld       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
        ptr_upd = vld;
`ifdef SDRAM_ARB_PRIO0_EN
        // Requester 0 overrides; the others keep their rotation untouched.
        if (req[0]) begin
            gnt     = '0;
            gnt[0]  = 1'b1;
            idx     = '0;
            ptr_upd = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller among NUM_REQ requesters, one transaction at a time (optional SDRAM_ARB_PRIO0_EN).
// Grant to ACK is DONE_EDGES MC_RDY rises plus 2 cycles; requesters hold REQ until ACK, hung ops abort after TIMEOUT.
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BANK_ADRESS  = SDRAM_BANK_ADRESS,
    parameter int ROW_ADRESS   = SDRAM_ROW_ADRESS,
    parameter int COLUMN_WIDTH = SDRAM_COLUMN_WIDTH,
    parameter int DONE_EDGES   = 2,
    parameter int TIMEOUT      = 1024
) (
    input  logic                             CLK,
    input  logic                             NRST,
    input  logic [NUM_REQ-1:0]               REQ,
    input  logic [NUM_REQ-1:0]               REQ_WE,
    input  logic [NUM_REQ*ROW_ADRESS-1:0]    REQ_ADR,
    input  logic [NUM_REQ*BANK_ADRESS-1:0]   REQ_BDR,
    input  logic [NUM_REQ*COLUMN_WIDTH-1:0]  REQ_DIN,
    output logic [NUM_REQ-1:0]               GNT,
    output logic [NUM_REQ-1:0]               ACK,
    output logic                             ERR,
    output logic [COLUMN_WIDTH-1:0]          RDATA,
    output logic [ROW_ADRESS-1:0]            MC_ADR,
    output logic [BANK_ADRESS-1:0]           MC_BDR,
    output logic [COLUMN_WIDTH-1:0]          MC_DIN,
    output logic                             MC_RE,
    output logic                             MC_WE,
    input  logic                             MC_RDY,
    input  logic [COLUMN_WIDTH-1:0]          MC_DOUT
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int EW = $clog2(DONE_EDGES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [ROW_ADRESS-1:0]   adr_arr [NUM_REQ];
    logic [BANK_ADRESS-1:0]  bdr_arr [NUM_REQ];
    logic [COLUMN_WIDTH-1:0] din_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign adr_arr[i] = REQ_ADR[i*ROW_ADRESS   +: ROW_ADRESS];
        assign bdr_arr[i] = REQ_BDR[i*BANK_ADRESS  +: BANK_ADRESS];
        assign din_arr[i] = REQ_DIN[i*COLUMN_WIDTH +: COLUMN_WIDTH];
    end

    logic [1:0]              state_q,    state_d;
    logic [NUM_REQ-1:0]      gnt_q,      gnt_d;
    logic [NUM_REQ-1:0]      ack_q,      ack_d;
    logic                    err_q,      err_d;
    logic                    mc_re_q,    mc_re_d;
    logic                    mc_we_q,    mc_we_d;
    logic [ROW_ADRESS-1:0]   mc_adr_q,   mc_adr_d;
    logic [BANK_ADRESS-1:0]  mc_bdr_q,   mc_bdr_d;
    logic [COLUMN_WIDTH-1:0] mc_din_q,   mc_din_d;
    logic [COLUMN_WIDTH-1:0] rdata_q,    rdata_d;
    logic [PW-1:0]           ptr_q,      ptr_d;
    logic [EW-1:0]           edge_cnt_q, edge_cnt_d;
    logic [TW-1:0]           to_cnt_q,   to_cnt_d;
    logic                    rdy_prev_q, rdy_prev_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [PW-1:0]      arb_idx;
    logic               arb_vld;
    logic               arb_ptr_upd;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr_arbiter (
        .req     (REQ),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .idx     (arb_idx),
        .vld     (arb_vld),
        .ptr_upd (arb_ptr_upd)
    );

    logic          rdy_rise;
    logic [TW-1:0] to_inc;
    logic [EW-1:0] edge_inc;
    logic          to_hit;
    logic          fin_ok;
    logic          fin_to;

    always_comb begin
        rdy_rise = MC_RDY & ~rdy_prev_q;
        to_inc   = (to_cnt_q == TW'(TIMEOUT)) ? to_cnt_q : to_cnt_q + TW'(1);
        to_hit   = (to_inc == TW'(TIMEOUT));
        edge_inc = edge_cnt_q + EW'(1);

        state_d    = state_q;
        gnt_d      = gnt_q;
        ack_d      = '0;
        err_d      = 1'b0;
        mc_re_d    = mc_re_q;
        mc_we_d    = mc_we_q;
        mc_adr_d   = mc_adr_q;
        mc_bdr_d   = mc_bdr_q;
        mc_din_d   = mc_din_q;
        rdata_d    = rdata_q;
        ptr_d      = ptr_q;
        edge_cnt_d = edge_cnt_q;
        to_cnt_d   = to_cnt_q;
        rdy_prev_d = MC_RDY;
        fin_ok     = 1'b0;
        fin_to     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                edge_cnt_d = '0;
                to_cnt_d   = '0;
                // MC_RDY low means the controller is still in init or refresh.
                if (arb_vld && MC_RDY) begin
                    gnt_d    = arb_gnt;
                    mc_we_d  = REQ_WE[arb_idx];
                    mc_re_d  = ~REQ_WE[arb_idx];
                    mc_adr_d = adr_arr[arb_idx];
                    mc_bdr_d = bdr_arr[arb_idx];
                    mc_din_d = din_arr[arb_idx];
                    if (arb_ptr_upd) begin
                        ptr_d = arb_idx;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                edge_cnt_d = '0;
                to_cnt_d   = to_inc;
                if (to_hit) begin
                    fin_to = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                to_cnt_d = to_inc;
                if (rdy_rise) begin
                    edge_cnt_d = edge_inc;
                end
                if (rdy_rise && (edge_inc == EW'(DONE_EDGES))) begin
                    fin_ok = 1'b1;
                end else if (to_hit) begin
                    fin_to = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fin_ok || fin_to) begin
            state_d = ST_DONE;
            ack_d   = gnt_q;
            err_d   = fin_to;
            gnt_d   = '0;
            mc_re_d = 1'b0;
            mc_we_d = 1'b0;
            if (fin_ok && !mc_we_q) begin
                rdata_d = MC_DOUT;
            end
        end
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            mc_re_q    <= 1'b0;
            mc_we_q    <= 1'b0;
            mc_adr_q   <= '0;
            mc_bdr_q   <= '0;
            mc_din_q   <= '0;
            rdata_q    <= '0;
            ptr_q      <= PW'(NUM_REQ - 1);
            edge_cnt_q <= '0;
            to_cnt_q   <= '0;
            rdy_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            mc_re_q    <= mc_re_d;
            mc_we_q    <= mc_we_d;
            mc_adr_q   <= mc_adr_d;
            mc_bdr_q   <= mc_bdr_d;
            mc_din_q   <= mc_din_d;
            rdata_q    <= rdata_d;
            ptr_q      <= ptr_d;
            edge_cnt_q <= edge_cnt_d;
            to_cnt_q   <= to_cnt_d;
            rdy_prev_q <= rdy_prev_d;
        end
    end

    assign GNT    = gnt_q;
    assign ACK    = ack_q;
    assign ERR    = err_q;
    assign RDATA  = rdata_q;
    assign MC_ADR = mc_adr_q;
    assign MC_BDR = mc_bdr_q;
    assign MC_DIN = mc_din_q;
    assign MC_RE  = mc_re_q;
    assign MC_WE  = mc_we_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a hand-driven MC_RDY controller model.
module tb_sdram_port_arbiter;

    logic        CLK;
    logic        NRST;
    logic [3:0]  REQ;
    logic [3:0]  REQ_WE;
    logic [51:0] REQ_ADR;
    logic [7:0]  REQ_BDR;
    logic [63:0] REQ_DIN;
    logic [3:0]  GNT;
    logic [3:0]  ACK;
    logic        ERR;
    logic [15:0] RDATA;
    logic [12:0] MC_ADR;
    logic [1:0]  MC_BDR;
    logic [15:0] MC_DIN;
    logic        MC_RE;
    logic        MC_WE;
    logic        MC_RDY;
    logic [15:0] MC_DOUT;

    int errors;
    int checks;
    int n;
    logic seen;

    sdram_port_arbiter #(
        .NUM_REQ      (4),
        .BANK_ADRESS  (2),
        .ROW_ADRESS   (13),
        .COLUMN_WIDTH (16),
        .DONE_EDGES   (2),
        .TIMEOUT      (1024)
    ) dut (
        .CLK     (CLK),
        .NRST    (NRST),
        .REQ     (REQ),
        .REQ_WE  (REQ_WE),
        .REQ_ADR (REQ_ADR),
        .REQ_BDR (REQ_BDR),
        .REQ_DIN (REQ_DIN),
        .GNT     (GNT),
        .ACK     (ACK),
        .ERR     (ERR),
        .RDATA   (RDATA),
        .MC_ADR  (MC_ADR),
        .MC_BDR  (MC_BDR),
        .MC_DIN  (MC_DIN),
        .MC_RE   (MC_RE),
        .MC_WE   (MC_WE),
        .MC_RDY  (MC_RDY),
        .MC_DOUT (MC_DOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Two MC_RDY rising edges after the grant cycle; ACK is visible on return.
    task automatic serve();
        MC_RDY = 1'b0;
        step();
        step();
        MC_RDY = 1'b1;
        step();
        MC_RDY = 1'b0;
        step();
        MC_RDY = 1'b1;
        step();
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        n       = 0;
        seen    = 1'b0;
        NRST    = 1'b0;
        REQ     = '0;
        REQ_WE  = '0;
        REQ_ADR = '0;
        REQ_BDR = '0;
        REQ_DIN = '0;
        MC_RDY  = 1'b1;
        MC_DOUT = 16'hBEEF;
        step();
        step();
        step();
        chk("rst_gnt",   GNT,    32'h0);
        chk("rst_ack",   ACK,    32'h0);
        chk("rst_err",   ERR,    32'h0);
        chk("rst_re",    MC_RE,  32'h0);
        chk("rst_we",    MC_WE,  32'h0);
        chk("rst_adr",   MC_ADR, 32'h0);
        chk("rst_rdata", RDATA,  32'h0);
        NRST = 1'b1;

        // Single read from requester 0; REQ dropped right after grant.
        REQ_ADR[0 +: 13] = 13'h0123;
        REQ = 4'b0001;
        step();
        chk("rd_gnt", GNT,    32'h1);
        chk("rd_re",  MC_RE,  32'h1);
        chk("rd_we",  MC_WE,  32'h0);
        chk("rd_adr", MC_ADR, 32'h0123);
        REQ = 4'b0000;
        MC_RDY = 1'b0;
        step();
        step();
        MC_RDY = 1'b1;
        step();
        chk("rd_ack_after_1edge", ACK,   32'h0);
        chk("rd_re_held",         MC_RE, 32'h1);
        MC_RDY = 1'b0;
        step();
        MC_RDY = 1'b1;
        step();
        chk("rd_ack",   ACK,   32'h1);
        chk("rd_err",   ERR,   32'h0);
        chk("rd_rdata", RDATA, 32'hBEEF);
        chk("rd_re_off", MC_RE, 32'h0);
        chk("rd_gnt_off", GNT,  32'h0);
        step();
        chk("rd_ack_pulse", ACK, 32'h0);

        // Write from requester 2; inputs changed after grant must be ignored.
        REQ_ADR[26 +: 13] = 13'h0456;
        REQ_BDR[4 +: 2]   = 2'b10;
        REQ_DIN[32 +: 16] = 16'hA5A5;
        REQ_WE  = 4'b0100;
        REQ     = 4'b0100;
        MC_DOUT = 16'h1111;
        step();
        chk("wr_gnt", GNT,    32'h4);
        chk("wr_we",  MC_WE,  32'h1);
        chk("wr_re",  MC_RE,  32'h0);
        chk("wr_din", MC_DIN, 32'hA5A5);
        chk("wr_bdr", MC_BDR, 32'h2);
        REQ_DIN[32 +: 16] = 16'hFFFF;
        REQ = 4'b0000;
        serve();
        chk("wr_ack",      ACK,    32'h4);
        chk("wr_rdata",    RDATA,  32'hBEEF);
        chk("wr_din_hold", MC_DIN, 32'hA5A5);
        REQ_WE = 4'b0000;
        step();

        // Hung read from requester 3: controller never raises MC_RDY.
        REQ_ADR[39 +: 13] = 13'h0789;
        REQ = 4'b1000;
        step();
        chk("hang_gnt", GNT, 32'h8);
        REQ = 4'b0000;
        MC_RDY = 1'b0;
        n = 0;
        while (ACK == 4'b0000 && n < 2000) begin
            step();
            n++;
        end
        chk("hang_cycles", n,     32'd1024);
        chk("hang_ack",    ACK,   32'h8);
        chk("hang_err",    ERR,   32'h1);
        chk("hang_rdata",  RDATA, 32'hBEEF);
        chk("hang_re_off", MC_RE, 32'h0);
        MC_RDY = 1'b1;
        step();
        chk("hang_err_pulse", ERR, 32'h0);

        // Contention: all four requesting, pointer sits at 3 so order starts at 0.
        for (int i = 0; i < 4; i++) begin
            REQ_ADR[i*13 +: 13] = 13'(32'h100 + i);
        end
        REQ = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (GNT == 4'b0000 && n < 20) begin
                step();
                n++;
            end
            chk($sformatf("cont%0d_gnt", k), GNT, 32'h1 << (k % 4));
            chk($sformatf("cont%0d_onehot", k), $countones(GNT), 32'd1);
            chk($sformatf("cont%0d_adr", k), MC_ADR, 32'h100 + (k % 4));
            if (k > 0) begin
                chk($sformatf("cont%0d_gap", k), n, 32'd2);
            end
            MC_DOUT = 16'(32'h5000 + k);
            serve();
            chk($sformatf("cont%0d_ack", k), ACK, 32'h1 << (k % 4));
            chk($sformatf("cont%0d_rdata", k), RDATA, 32'h5000 + k);
            chk($sformatf("cont%0d_err", k), ERR, 32'h0);
        end
        REQ = 4'b0000;
        step();

        // Init gating: controller busy for 100 cycles.
        MC_RDY = 1'b0;
        REQ    = 4'b0010;
        seen   = 1'b0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (GNT != 4'b0000) seen = 1'b1;
        end
        chk("init_no_gnt", seen, 32'h0);
        MC_RDY = 1'b1;
        step();
        chk("init_gnt", GNT, 32'h2);
        REQ = 4'b0000;
        serve();
        chk("init_ack", ACK, 32'h2);
        step();

        // Reset in the middle of WAIT for requester 2.
        REQ = 4'b0100;
        step();
        chk("mrst_gnt", GNT, 32'h4);
        MC_RDY = 1'b0;
        step();
        step();
        chk("mrst_re_wait", MC_RE, 32'h1);
        NRST = 1'b0;
        #1;
        chk("mrst_gnt_clr",  GNT,    32'h0);
        chk("mrst_re_clr",   MC_RE,  32'h0);
        chk("mrst_adr_clr",  MC_ADR, 32'h0);
        chk("mrst_din_clr",  MC_DIN, 32'h0);
        chk("mrst_rdata_clr", RDATA, 32'h0);
        chk("mrst_ack",      ACK,    32'h0);
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (ACK != 4'b0000) seen = 1'b1;
        end
        chk("mrst_no_ack", seen, 32'h0);
        MC_RDY = 1'b1;
        REQ    = 4'b1111;
        NRST   = 1'b1;
        step();
        chk("mrst_first_winner", GNT, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
